cache_way_array: RTL and testbench
==================================

CACHE_WAY_ARRAY -- requirements
Module: cache_way_array

Interface
REQ-001 SHALL have parameter WAYS, default 4, associativity (power of two, 2..8).
REQ-002 SHALL have parameter INDEX_BIT, default 6, set index width; sets = 1<<INDEX_BIT, with no modulo folding.
REQ-003 SHALL have parameter TAG_BIT, default 20, stored tag width.
REQ-004 SHALL have parameter BLOCK_SIZE_WORDS, default 4, 32-bit words per line; word 0 occupies the most-significant 32 bits.
REQ-005 SHALL have these ports:
- clk  in  1  clock, single domain.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid&req_ready at a rising edge.
- req_op  in  2  00 READ, 01 WRITE (word), 10 FILL (line), 11 INVAL.
- req_tag  in  TAG_BIT  lookup tag.
- req_index  in  INDEX_BIT  set index.
- req_word  in  log2(BLOCK_SIZE_WORDS)  word select for READ/WRITE.
- req_wdata  in  32  WRITE data.
- req_fill_data  in  32*BLOCK_SIZE_WORDS  FILL line data.
- resp_valid  out  1  one-cycle response strobe.
- resp_hit  out  1  tag matched a valid way.
- resp_way  out  log2(WAYS)  hit way, or on a miss the victim way.
- resp_rdata  out  32  selected word on a READ hit.
- resp_wb  out  1  reported victim line is valid and dirty.
- resp_victim_tag  out  TAG_BIT  tag of the evicted or invalidated line.
- resp_victim_data  out  32*BLOCK_SIZE_WORDS  data of the evicted or invalidated line.

Function
REQ-006 SHALL use FSM states IDLE and ACCESS; req_ready=1 only in IDLE; acceptance moves IDLE->ACCESS, and the next edge moves ACCESS->IDLE.
REQ-007 SHALL read all ways' tag/data synchronously at the acceptance edge T, and compare, commit writes, and register the response at edge T+1; resp_valid is high for exactly the cycle after T+1.
REQ-008 SHALL sustain a maximum throughput of one request per 2 cycles; the response has no backpressure.
REQ-009 SHALL define hit as valid[way] && tag[way]==req_tag; at most one way hits by construction.
REQ-010 SHALL select the victim on a miss as the lowest-index invalid way, else the tree-pLRU way.
REQ-011 SHALL implement tree pLRU with WAYS-1 bits per set:
- bit=0 points left.
- A "touch" sets the path bits to point away from the touched way.
REQ-012 SHALL handle READ as follows:
- Hit: resp_hit=1, resp_rdata=word, touch.
- Miss: resp_hit=0, resp_way=victim, victim fields reported, no state change.
REQ-013 SHALL handle WRITE as follows:
- Hit: write req_wdata into the word, set dirty, touch.
- Miss: no array change (no write-allocate), resp_hit=0.
REQ-014 SHALL handle FILL as follows:
- Hit: overwrite that way's line and clear dirty.
- Miss: report the victim (resp_wb = valid&dirty), then install tag/data in the victim way, set valid, clear dirty.
- Both cases touch.
REQ-015 SHALL handle INVAL as follows:
- Hit: clear valid, report the line in the victim fields with resp_wb = dirty; pLRU unchanged.
- Miss: no change.
REQ-016 SHALL drive resp_rdata, resp_victim_* and resp_wb to 0 when they do not apply.

Reset
REQ-017 SHALL, while rst_n=0, clear the FSM to IDLE, all outputs to 0 (req_ready=0 during reset), and all valid, dirty and pLRU flops to 0.
REQ-018 SHALL make reset during ACCESS abort the operation: no array write, no resp_valid.
REQ-019 SHALL not reset the tag/data arrays; they are qualified by valid only.

Structure
REQ-020 SHALL place the op encodings, FSM state enum and width helper functions in package cache_pkg.
REQ-021 SHALL implement victim/update logic in sub-module cache_plru_tree (combinational, WAYS parameter), shared by all sets.

Verification (WAYS=4, INDEX_BIT=6, TAG_BIT=20, BLOCK_SIZE_WORDS=4)
REQ-022 SHALL cover: after reset, READ tag 0x12 idx 5 -> resp_hit=0, resp_way=0, resp_wb=0.
REQ-023 SHALL cover: FILL tag 0x12 idx 5 data words {0,1,2,3} -> way 0; then READ word 2 -> resp_hit=1, resp_way=0, resp_rdata=0x00000002.
REQ-024 SHALL cover: FILL tags A,B,C,D idx 5 -> ways 0..3; READ A; FILL E -> resp_way=2, resp_wb=0, resp_victim_tag=C.
REQ-025 SHALL cover: idx 9 FILL 0x1; WRITE word 1 = 0xDEADBEEF; FILL 0x2, 0x3, 0x4; FILL 0x5 -> resp_way=0, resp_wb=1, victim_tag=0x1, victim word 1 = 0xDEADBEEF.
REQ-026 SHALL cover: accept READ, pull rst_n low in ACCESS -> no resp_valid; after release req_ready=1 and a previously filled line misses.
REQ-027 SHALL cover: req_valid held high for two ops -> req_ready sequence 1,0,1, second response exactly 2 cycles after the first.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared encodings and width helpers for the set-associative way array.
package cache_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_INVAL = 2'b11
  } cache_op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } cache_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = 32'sd1;
    while ((32'sd1 << w) < n) begin
      w = w + 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cache_plru_tree.sv
// Tree pseudo-LRU for one set: victim choice (invalid ways first) and path touch.
module cache_plru_tree
  import cache_pkg::*;
#(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]            plru_bits,
  input  logic [WAYS-1:0]            valid,
  input  logic [idx_width(WAYS)-1:0] touch_way,
  output logic [idx_width(WAYS)-1:0] victim_way,
  output logic [WAYS-2:0]            plru_touched
);

  localparam int WAY_W = idx_width(WAYS);

  int   v_node_s;
  int   t_node_s;
  logic found_s;

  // Victim: follow the pointers from the root (bit 0 = left), overridden by the lowest invalid way.
  always_comb begin
    v_node_s = 0;
    for (int l = 0; l < WAY_W; l++) begin
      v_node_s = plru_bits[v_node_s] ? (2 * v_node_s + 2) : (2 * v_node_s + 1);
    end
    victim_way = WAY_W'(v_node_s - (WAYS - 1));
    found_s    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_s && !valid[w]) begin
        victim_way = WAY_W'(w);
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Touch: each node on the path to touch_way is set to point at the other subtree.
  always_comb begin
    plru_touched = plru_bits;
    t_node_s     = 0;
    for (int l = 0; l < WAY_W; l++) begin
      plru_touched[t_node_s] = ~touch_way[WAY_W-1-l];
      t_node_s = 2 * t_node_s + 1 + int'(touch_way[WAY_W-1-l]);
    end
  end

endmodule

// File: rtl/cache_way_array.sv
// Set-associative tag/data way array: one request per two cycles, pLRU replacement,
// READ / WRITE / FILL / INVAL with victim reporting.
module cache_way_array
  import cache_pkg::*;
#(
  parameter int WAYS             = 4,
  parameter int INDEX_BIT        = 6,
  parameter int TAG_BIT          = 20,
  parameter int BLOCK_SIZE_WORDS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [1:0]                           req_op,
  input  logic [TAG_BIT-1:0]                   req_tag,
  input  logic [INDEX_BIT-1:0]                 req_index,
  input  logic [idx_width(BLOCK_SIZE_WORDS)-1:0] req_word,
  input  logic [31:0]                          req_wdata,
  input  logic [32*BLOCK_SIZE_WORDS-1:0]       req_fill_data,
  output logic                                 resp_valid,
  output logic                                 resp_hit,
  output logic [idx_width(WAYS)-1:0]           resp_way,
  output logic [31:0]                          resp_rdata,
  output logic                                 resp_wb,
  output logic [TAG_BIT-1:0]                   resp_victim_tag,
  output logic [32*BLOCK_SIZE_WORDS-1:0]       resp_victim_data
);

  localparam int SETS   = 1 << INDEX_BIT;
  localparam int WAY_W  = idx_width(WAYS);
  localparam int WORD_W = idx_width(BLOCK_SIZE_WORDS);
  localparam int LINE_W = 32 * BLOCK_SIZE_WORDS;

  cache_state_e state_r, state_nxt_s;
  logic accept_s, access_s;

  logic [1:0]           q_op_r;
  logic [TAG_BIT-1:0]   q_tag_r;
  logic [INDEX_BIT-1:0] q_index_r;
  logic [WORD_W-1:0]    q_word_r;
  logic [31:0]          q_wdata_r;
  logic [LINE_W-1:0]    q_fill_r;

  logic [TAG_BIT-1:0] tag_mem_r  [SETS][WAYS];
  logic [LINE_W-1:0]  data_mem_r [SETS][WAYS];
  logic [TAG_BIT-1:0] rd_tag_r   [WAYS];
  logic [LINE_W-1:0]  rd_data_r  [WAYS];
  logic [WAYS-1:0]    valid_r    [SETS];
  logic [WAYS-1:0]    dirty_r    [SETS];
  logic [WAYS-2:0]    plru_r     [SETS];

  logic [WAYS-1:0]   valid_cur_s, dirty_cur_s, hit_vec_s, valid_nxt_s, dirty_nxt_s;
  logic [WAYS-2:0]   plru_cur_s, plru_touched_s, plru_nxt_s;
  logic              hit_s, mem_we_s, wb_s;
  logic [WAY_W-1:0]  hit_way_s, victim_s, sel_way_s;
  logic [TAG_BIT-1:0] sel_tag_s, vtag_s;
  logic [LINE_W-1:0] sel_data_s, merged_s, mem_data_s, vdata_s;
  logic [31:0]       sel_word_s, rdata_s;

  assign accept_s    = req_valid && req_ready;
  assign access_s    = (state_r == ACCESS);
  assign valid_cur_s = valid_r[q_index_r];
  assign dirty_cur_s = dirty_r[q_index_r];
  assign plru_cur_s  = plru_r[q_index_r];
  assign sel_way_s   = hit_s ? hit_way_s : victim_s;

  // Next-state logic: one ACCESS cycle per accepted request.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = accept_s ? ACCESS : IDLE;
      ACCESS:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register; req_ready is registered so it stays low throughout reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      req_ready <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      req_ready <= (state_nxt_s == IDLE);
    end
  end

  // Request capture at the acceptance edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_op_r    <= 2'b00;
      q_tag_r   <= '0;
      q_index_r <= '0;
      q_word_r  <= '0;
      q_wdata_r <= 32'h0;
      q_fill_r  <= '0;
    end else if (accept_s) begin
      q_op_r    <= req_op;
      q_tag_r   <= req_tag;
      q_index_r <= req_index;
      q_word_r  <= req_word;
      q_wdata_r <= req_wdata;
      q_fill_r  <= req_fill_data;
    end
  end

  cache_plru_tree #(.WAYS(WAYS)) u_plru (
    .plru_bits    (plru_cur_s),
    .valid        (valid_cur_s),
    .touch_way    (sel_way_s),
    .victim_way   (victim_s),
    .plru_touched (plru_touched_s)
  );

  // Tag compare against the ways read out at the acceptance edge.
  always_comb begin
    hit_vec_s = '0;
    hit_way_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec_s[w] = valid_cur_s[w] && (rd_tag_r[w] == q_tag_r);
      if (hit_vec_s[w]) begin
        hit_way_s = WAY_W'(w);
      end else begin
        hit_way_s = hit_way_s;
      end
    end
    hit_s = |hit_vec_s;
  end

  // Selected line, word extract and word merge; word 0 is the most-significant slice.
  always_comb begin
    sel_tag_s  = rd_tag_r[sel_way_s];
    sel_data_s = rd_data_r[sel_way_s];
    sel_word_s = 32'h0;
    merged_s   = sel_data_s;
    for (int b = 0; b < BLOCK_SIZE_WORDS; b++) begin
      sel_word_s = (q_word_r == WORD_W'(b)) ? sel_data_s[32*(BLOCK_SIZE_WORDS-1-b) +: 32] : sel_word_s;
      merged_s[32*(BLOCK_SIZE_WORDS-1-b) +: 32] =
        (q_word_r == WORD_W'(b)) ? q_wdata_r : sel_data_s[32*(BLOCK_SIZE_WORDS-1-b) +: 32];
    end
  end

  // Per-op array, metadata and response decisions.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_data_s  = q_fill_r;
    valid_nxt_s = valid_cur_s;
    dirty_nxt_s = dirty_cur_s;
    plru_nxt_s  = plru_cur_s;
    rdata_s     = 32'h0;
    wb_s        = 1'b0;
    vtag_s      = '0;
    vdata_s     = '0;
    case (cache_op_e'(q_op_r))
      OP_READ: begin
        if (hit_s) begin
          rdata_s    = sel_word_s;
          plru_nxt_s = plru_touched_s;
        end else if (valid_cur_s[sel_way_s]) begin
          wb_s    = dirty_cur_s[sel_way_s];
          vtag_s  = sel_tag_s;
          vdata_s = sel_data_s;
        end else begin
          wb_s = 1'b0;
        end
      end
      OP_WRITE: begin
        if (hit_s) begin
          mem_we_s               = 1'b1;
          mem_data_s             = merged_s;
          dirty_nxt_s[sel_way_s] = 1'b1;
          plru_nxt_s             = plru_touched_s;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      OP_FILL: begin
        if (!hit_s && valid_cur_s[sel_way_s]) begin
          wb_s    = dirty_cur_s[sel_way_s];
          vtag_s  = sel_tag_s;
          vdata_s = sel_data_s;
        end else begin
          wb_s = 1'b0;
        end
        mem_we_s               = 1'b1;
        valid_nxt_s[sel_way_s] = 1'b1;
        dirty_nxt_s[sel_way_s] = 1'b0;
        plru_nxt_s             = plru_touched_s;
      end
      OP_INVAL: begin
        if (hit_s) begin
          valid_nxt_s[sel_way_s] = 1'b0;
          wb_s    = dirty_cur_s[sel_way_s];
          vtag_s  = sel_tag_s;
          vdata_s = sel_data_s;
        end else begin
          wb_s = 1'b0;
        end
      end
      default: mem_we_s = 1'b0;
    endcase
  end

  // Tag/data arrays: read at acceptance, written in ACCESS; not reset, qualified by valid.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int w = 0; w < WAYS; w++) begin
        rd_tag_r[w]  <= tag_mem_r[req_index][w];
        rd_data_r[w] <= data_mem_r[req_index][w];
      end
    end
    if (access_s && mem_we_s) begin
      tag_mem_r[q_index_r][sel_way_s]  <= q_tag_r;
      data_mem_r[q_index_r][sel_way_s] <= mem_data_s;
    end
  end

  // Valid, dirty and pLRU state per set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= '0;
        dirty_r[s] <= '0;
        plru_r[s]  <= '0;
      end
    end else if (access_s) begin
      valid_r[q_index_r] <= valid_nxt_s;
      dirty_r[q_index_r] <= dirty_nxt_s;
      plru_r[q_index_r]  <= plru_nxt_s;
    end
  end

  // Registered one-cycle response; all fields are zero outside the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid       <= 1'b0;
      resp_hit         <= 1'b0;
      resp_way         <= '0;
      resp_rdata       <= 32'h0;
      resp_wb          <= 1'b0;
      resp_victim_tag  <= '0;
      resp_victim_data <= '0;
    end else begin
      resp_valid       <= access_s;
      resp_hit         <= access_s && hit_s;
      resp_way         <= access_s ? sel_way_s : '0;
      resp_rdata       <= access_s ? rdata_s : 32'h0;
      resp_wb          <= access_s && wb_s;
      resp_victim_tag  <= access_s ? vtag_s : '0;
      resp_victim_data <= access_s ? vdata_s : '0;
    end
  end

endmodule

// File: tb/tb_cache_way_array.sv
// Directed table-driven bench for cache_way_array with hand-written multi-cycle sequences.
module tb_cache_way_array;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [19:0]  req_tag;
  logic [5:0]   req_index;
  logic [1:0]   req_word;
  logic [31:0]  req_wdata;
  logic [127:0] req_fill_data;
  logic         resp_valid;
  logic         resp_hit;
  logic [1:0]   resp_way;
  logic [31:0]  resp_rdata;
  logic         resp_wb;
  logic [19:0]  resp_victim_tag;
  logic [127:0] resp_victim_data;

  cache_way_array #(.WAYS(4), .INDEX_BIT(6), .TAG_BIT(20), .BLOCK_SIZE_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_tag(req_tag), .req_index(req_index), .req_word(req_word),
    .req_wdata(req_wdata), .req_fill_data(req_fill_data), .resp_valid(resp_valid),
    .resp_hit(resp_hit), .resp_way(resp_way), .resp_rdata(resp_rdata), .resp_wb(resp_wb),
    .resp_victim_tag(resp_victim_tag), .resp_victim_data(resp_victim_data)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, FL = 2'b10, IV = 2'b11;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [19:0]  tag;
    logic [5:0]   idx;
    logic [1:0]   word;
    logic [31:0]  wdata;
    logic [127:0] fill;
    logic         e_hit;
    logic [1:0]   e_way;
    logic [31:0]  e_rdata;
    logic         e_wb;
    bit           chk_v;
    logic [19:0]  e_vtag;
    logic [127:0] e_vdata;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] mkline(input logic [15:0] t);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[127-32*w -: 32] = {t, 16'(w)};
    return l;
  endfunction

  function automatic void add(input string nm, input logic [1:0] op, input logic [19:0] tag,
                              input logic [5:0] idx, input logic [1:0] word, input logic [31:0] wdata,
                              input logic [127:0] fill, input logic e_hit, input logic [1:0] e_way,
                              input logic [31:0] e_rdata, input logic e_wb, input bit chk_v,
                              input logic [19:0] e_vtag, input logic [127:0] e_vdata);
    vec_t v;
    v.name = nm; v.op = op; v.tag = tag; v.idx = idx; v.word = word; v.wdata = wdata;
    v.fill = fill; v.e_hit = e_hit; v.e_way = e_way; v.e_rdata = e_rdata; v.e_wb = e_wb;
    v.chk_v = chk_v; v.e_vtag = e_vtag; v.e_vdata = e_vdata;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic [1:0] op, input logic [19:0] tag, input logic [5:0] idx,
                       input logic [1:0] word, input logic [31:0] wdata, input logic [127:0] fill);
    req_op = op; req_tag = tag; req_index = idx; req_word = word;
    req_wdata = wdata; req_fill_data = fill;
  endtask

  // Waits (bounded) for ready, issues one request, returns at the negedge where the response is visible.
  task automatic issue(input string nm, input logic [1:0] op, input logic [19:0] tag, input logic [5:0] idx,
                       input logic [1:0] word, input logic [31:0] wdata, input logic [127:0] fill);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_ready"}, 128'(req_ready), 128'(1));
    drive(op, tag, idx, word, wdata, fill);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check({nm, "_resp_valid"}, 128'(resp_valid), 128'(1));
  endtask

  logic [127:0] d0123, l1_mod, l4_mod;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    drive(RD, 20'h0, 6'h0, 2'd0, 32'h0, 128'h0);

    d0123  = 128'h00000000_00000001_00000002_00000003;
    l1_mod = mkline(16'h0001); l1_mod[95:64]  = 32'hDEADBEEF;
    l4_mod = mkline(16'h0004); l4_mod[127:96] = 32'hCAFEF00D;

    //   name          op  tag       idx    wd    wdata          fill               hit   way   rdata          wb    chk  vtag      vdata
    add("rd_empty",    RD, 20'h12,   6'd5,  2'd0, 32'h0,         128'h0,            1'b0, 2'd0, 32'h0,         1'b0, 0,   20'h0,    128'h0);
    add("fill_first",  FL, 20'h12,   6'd5,  2'd0, 32'h0,         d0123,             1'b0, 2'd0, 32'h0,         1'b0, 0,   20'h0,    128'h0);
    add("rd_w2",       RD, 20'h12,   6'd5,  2'd2, 32'h0,         128'h0,            1'b1, 2'd0, 32'h2,         1'b0, 1,   20'h0,    128'h0);
    add("fill_a_hit",  FL, 20'h12,   6'd5,  2'd0, 32'h0,         mkline(16'h12),    1'b1, 2'd0, 32'h0,         1'b0, 1,   20'h0,    128'h0);
    add("fill_b",      FL, 20'h34,   6'd5,  2'd0, 32'h0,         mkline(16'h34),    1'b0, 2'd1, 32'h0,         1'b0, 0,   20'h0,    128'h0);
    add("fill_c",      FL, 20'h56,   6'd5,  2'd0, 32'h0,         mkline(16'h56),    1'b0, 2'd2, 32'h0,         1'b0, 0,   20'h0,    128'h0);
    add("fill_d",      FL, 20'h78,   6'd5,  2'd0, 32'h0,         mkline(16'h78),    1'b0, 2'd3, 32'h0,         1'b0, 0,   20'h0,    128'h0);
    add("rd_a",        RD, 20'h12,   6'd5,  2'd3, 32'h0,         128'h0,            1'b1, 2'd0, 32'h00120003,  1'b0, 1,   20'h0,    128'h0);
    add("fill_e",      FL, 20'h9A,   6'd5,  2'd0, 32'h0,         mkline(16'h9A),    1'b0, 2'd2, 32'h0,         1'b0, 1,   20'h56,   mkline(16'h56));
    add("rd_c_miss",   RD, 20'h56,   6'd5,  2'd0, 32'h0,         128'h0,            1'b0, 2'd1, 32'h0,         1'b0, 1,   20'h34,   mkline(16'h34));
    add("rd_e",        RD, 20'h9A,   6'd5,  2'd0, 32'h0,         128'h0,            1'b1, 2'd2, 32'h009A0000,  1'b0, 1,   20'h0,    128'h0);
    add("fill_1",      FL, 20'h1,    6'd9,  2'd0, 32'h0,         mkline(16'h1),     1'b0, 2'd0, 32'h0,         1'b0, 0,   20'h0,    128'h0);
    add("wr_1",        WR, 20'h1,    6'd9,  2'd1, 32'hDEADBEEF,  128'h0,            1'b1, 2'd0, 32'h0,         1'b0, 1,   20'h0,    128'h0);
    add("rd_1",        RD, 20'h1,    6'd9,  2'd1, 32'h0,         128'h0,            1'b1, 2'd0, 32'hDEADBEEF,  1'b0, 1,   20'h0,    128'h0);
    add("fill_2",      FL, 20'h2,    6'd9,  2'd0, 32'h0,         mkline(16'h2),     1'b0, 2'd1, 32'h0,         1'b0, 0,   20'h0,    128'h0);
    add("fill_3",      FL, 20'h3,    6'd9,  2'd0, 32'h0,         mkline(16'h3),     1'b0, 2'd2, 32'h0,         1'b0, 0,   20'h0,    128'h0);
    add("fill_4",      FL, 20'h4,    6'd9,  2'd0, 32'h0,         mkline(16'h4),     1'b0, 2'd3, 32'h0,         1'b0, 0,   20'h0,    128'h0);
    add("fill_5_wb",   FL, 20'h5,    6'd9,  2'd0, 32'h0,         mkline(16'h5),     1'b0, 2'd0, 32'h0,         1'b1, 1,   20'h1,    l1_mod);
    add("wr_miss",     WR, 20'h7,    6'd9,  2'd0, 32'h1234,      128'h0,            1'b0, 2'd2, 32'h0,         1'b0, 1,   20'h0,    128'h0);
    add("inv_3",       IV, 20'h3,    6'd9,  2'd0, 32'h0,         128'h0,            1'b1, 2'd2, 32'h0,         1'b0, 1,   20'h3,    mkline(16'h3));
    add("wr_4",        WR, 20'h4,    6'd9,  2'd0, 32'hCAFEF00D,  128'h0,            1'b1, 2'd3, 32'h0,         1'b0, 1,   20'h0,    128'h0);
    add("inv_4_dirty", IV, 20'h4,    6'd9,  2'd0, 32'h0,         128'h0,            1'b1, 2'd3, 32'h0,         1'b1, 1,   20'h4,    l4_mod);
    add("rd_4_miss",   RD, 20'h4,    6'd9,  2'd0, 32'h0,         128'h0,            1'b0, 2'd2, 32'h0,         1'b0, 0,   20'h0,    128'h0);
    add("inv_miss",    IV, 20'h4,    6'd9,  2'd0, 32'h0,         128'h0,            1'b0, 2'd2, 32'h0,         1'b0, 1,   20'h0,    128'h0);

    // Reset values while rst_n is low.
    #2;
    check("rst_ready", 128'(req_ready), 128'(0));
    check("rst_resp_valid", 128'(resp_valid), 128'(0));
    check("rst_hit", 128'(resp_hit), 128'(0));
    check("rst_way", 128'(resp_way), 128'(0));
    check("rst_rdata", 128'(resp_rdata), 128'(0));
    check("rst_wb", 128'(resp_wb), 128'(0));
    check("rst_vdata", resp_victim_data, 128'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i].name, vecs[i].op, vecs[i].tag, vecs[i].idx, vecs[i].word, vecs[i].wdata, vecs[i].fill);
      check({vecs[i].name, "_hit"},   128'(resp_hit),   128'(vecs[i].e_hit));
      check({vecs[i].name, "_way"},   128'(resp_way),   128'(vecs[i].e_way));
      check({vecs[i].name, "_rdata"}, 128'(resp_rdata), 128'(vecs[i].e_rdata));
      check({vecs[i].name, "_wb"},    128'(resp_wb),    128'(vecs[i].e_wb));
      if (vecs[i].chk_v) begin
        check({vecs[i].name, "_vtag"},  128'(resp_victim_tag), 128'(vecs[i].e_vtag));
        check({vecs[i].name, "_vdata"}, resp_victim_data,      vecs[i].e_vdata);
      end
    end

    // Back-to-back: req_valid held high across two requests.
    @(negedge clk);
    check("b2b_ready0", 128'(req_ready), 128'(1));
    drive(RD, 20'h12, 6'd5, 2'd1, 32'h0, 128'h0);
    req_valid = 1'b1;
    @(negedge clk);
    check("b2b_ready1", 128'(req_ready), 128'(0));
    check("b2b_noresp1", 128'(resp_valid), 128'(0));
    drive(RD, 20'h9A, 6'd5, 2'd3, 32'h0, 128'h0);
    @(negedge clk);
    check("b2b_ready2", 128'(req_ready), 128'(1));
    check("b2b_resp1_valid", 128'(resp_valid), 128'(1));
    check("b2b_resp1_rdata", 128'(resp_rdata), 128'(32'h00120001));
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_gap", 128'(resp_valid), 128'(0));
    @(negedge clk);
    check("b2b_resp2_valid", 128'(resp_valid), 128'(1));
    check("b2b_resp2_way", 128'(resp_way), 128'(2));
    check("b2b_resp2_rdata", 128'(resp_rdata), 128'(32'h009A0003));

    // Reset while a READ is in ACCESS aborts it.
    @(negedge clk);
    check("abort_ready", 128'(req_ready), 128'(1));
    drive(RD, 20'h12, 6'd5, 2'd0, 32'h0, 128'h0);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_in_access", 128'(req_ready), 128'(0));
    rst_n = 1'b0;
    #1;
    check("abort_ready_rst", 128'(req_ready), 128'(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort_noresp%0d", k), 128'(resp_valid), 128'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_noresp_rel", 128'(resp_valid), 128'(0));
    check("abort_ready_rel", 128'(req_ready), 128'(1));
    issue("post_rst_rd", RD, 20'h12, 6'd5, 2'd0, 32'h0, 128'h0);
    check("post_rst_hit", 128'(resp_hit), 128'(0));
    check("post_rst_way", 128'(resp_way), 128'(0));
    check("post_rst_wb", 128'(resp_wb), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
